// File: rtl/dual_car_scheduler.sv
// Two-car elevator scheduler: latches floor requests, assigns each pending floor to
// car A or B, and sequences every car through move, door-open and emergency-halt states.
module dual_car_scheduler #(
    parameter int FLOOR_TRAVEL_CYCLES = 4,
    parameter int DOOR_OPEN_CYCLES    = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] arbiter_requests,
    input  logic       emergency_override,
    output logic [3:0] pending_requests,
    output logic [1:0] car_a_floor,
    output logic [1:0] car_b_floor,
    output logic [1:0] car_a_dir,
    output logic [1:0] car_b_dir,
    output logic       car_a_door,
    output logic       car_b_door,
    output logic [3:0] served_pulse
);
    localparam int MAX_CYCLES = (FLOOR_TRAVEL_CYCLES > DOOR_OPEN_CYCLES) ? FLOOR_TRAVEL_CYCLES : DOOR_OPEN_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
    localparam logic [CNT_W-1:0] TRAVEL_LAST = CNT_W'(FLOOR_TRAVEL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DOOR_LAST   = CNT_W'(DOOR_OPEN_CYCLES - 1);
    localparam logic [1:0] DIR_IDLE = 2'b00;
    localparam logic [1:0] DIR_UP   = 2'b01;
    localparam logic [1:0] DIR_DOWN = 2'b10;

    typedef enum logic [1:0] {IDLE = 2'd0, MOVE = 2'd1, DOOR_OPEN = 2'd2, HALT = 2'd3} car_state_e;

    car_state_e       state_q [2];
    car_state_e       state_d [2];
    logic [1:0]       floor_q [2];
    logic [1:0]       floor_d [2];
    logic [1:0]       dir_q [2];
    logic [1:0]       dir_d [2];
    logic [1:0]       target_q [2];
    logic [1:0]       target_d [2];
    logic             tvalid_q [2];
    logic             tvalid_d [2];
    logic             door_q [2];
    logic             door_d [2];
    logic [CNT_W-1:0] cnt_q [2];
    logic [CNT_W-1:0] cnt_d [2];
    logic [3:0]       pending_q, pending_d;
    logic [3:0]       served_q, served_d;

    logic [3:0]       tmask_s [2];
    logic [2:0]       pick_s [2];
    logic [3:0]       a_elig_s, b_elig_s, a_pick_mask_s, clear_s;
    logic [1:0]       step_s;
    logic             halt_s;

    function automatic logic [1:0] floor_dist(input logic [1:0] x, input logic [1:0] y);
        return (x > y) ? (x - y) : (y - x);
    endfunction

    // Returns {found, floor}; the strict compare makes ties fall to the lower floor.
    function automatic logic [2:0] pick_nearest(input logic [3:0] elig, input logic [1:0] from);
        logic       found;
        logic [1:0] best;
        logic [1:0] best_d;
        logic [1:0] d;
        found  = 1'b0;
        best   = 2'd0;
        best_d = 2'd0;
        for (int i = 0; i < 4; i++) begin
            d = floor_dist(2'(i), from);
            if (elig[i] && (!found || (d < best_d))) begin
                found  = 1'b1;
                best   = 2'(i);
                best_d = d;
            end else begin
                found = found;
            end
        end
        return {found, best};
    endfunction

    // Floor assignment, per-car motion/door sequencing and pending-set update.
    always_comb begin
        halt_s        = emergency_override || (state_q[0] == HALT) || (state_q[1] == HALT);
        served_d      = 4'b0000;
        clear_s       = 4'b0000;
        step_s        = 2'd0;
        a_elig_s      = 4'b0000;
        for (int c = 0; c < 2; c++) begin
            tmask_s[c] = tvalid_q[c] ? (4'b0001 << target_q[c]) : 4'b0000;
        end
        // With both cars idle, A only takes floors it is at least as close to as B.
        for (int i = 0; i < 4; i++) begin
            a_elig_s[i] = pending_q[i] && !tmask_s[1][i] &&
                          ((state_q[1] != IDLE) ||
                           (floor_dist(2'(i), floor_q[0]) <= floor_dist(2'(i), floor_q[1])));
        end
        pick_s[0]     = (state_q[0] == IDLE) ? pick_nearest(a_elig_s, floor_q[0]) : 3'b000;
        a_pick_mask_s = pick_s[0][2] ? (4'b0001 << pick_s[0][1:0]) : 4'b0000;
        b_elig_s      = pending_q & ~tmask_s[0] & ~a_pick_mask_s;
        pick_s[1]     = (state_q[1] == IDLE) ? pick_nearest(b_elig_s, floor_q[1]) : 3'b000;

        for (int c = 0; c < 2; c++) begin
            state_d[c]  = state_q[c];
            floor_d[c]  = floor_q[c];
            dir_d[c]    = dir_q[c];
            door_d[c]   = door_q[c];
            target_d[c] = target_q[c];
            tvalid_d[c] = tvalid_q[c];
            cnt_d[c]    = cnt_q[c];
            if (emergency_override) begin
                state_d[c]  = HALT;
                dir_d[c]    = DIR_IDLE;
                door_d[c]   = 1'b0;
                cnt_d[c]    = {CNT_W{1'b0}};
                target_d[c] = 2'd0;
                tvalid_d[c] = 1'b0;
            end else begin
                case (state_q[c])
                    IDLE: begin
                        if (pick_s[c][2] && (pick_s[c][1:0] == floor_q[c])) begin
                            state_d[c] = DOOR_OPEN;
                            door_d[c]  = 1'b1;
                            cnt_d[c]   = {CNT_W{1'b0}};
                            served_d[pick_s[c][1:0]] = 1'b1;
                        end else if (pick_s[c][2]) begin
                            state_d[c]  = MOVE;
                            target_d[c] = pick_s[c][1:0];
                            tvalid_d[c] = 1'b1;
                            dir_d[c]    = (pick_s[c][1:0] > floor_q[c]) ? DIR_UP : DIR_DOWN;
                            cnt_d[c]    = {CNT_W{1'b0}};
                        end else begin
                            state_d[c] = IDLE;
                        end
                    end
                    MOVE: begin
                        if (cnt_q[c] == TRAVEL_LAST) begin
                            step_s     = (dir_q[c] == DIR_UP) ? (floor_q[c] + 2'd1) : (floor_q[c] - 2'd1);
                            floor_d[c] = step_s;
                            cnt_d[c]   = {CNT_W{1'b0}};
                            if (step_s == target_q[c]) begin
                                state_d[c]  = DOOR_OPEN;
                                dir_d[c]    = DIR_IDLE;
                                door_d[c]   = 1'b1;
                                tvalid_d[c] = 1'b0;
                                target_d[c] = 2'd0;
                                served_d[target_q[c]] = 1'b1;
                            end else begin
                                state_d[c] = MOVE;
                            end
                        end else begin
                            cnt_d[c] = cnt_q[c] + CNT_W'(1);
                        end
                    end
                    DOOR_OPEN: begin
                        if (cnt_q[c] == DOOR_LAST) begin
                            state_d[c] = IDLE;
                            door_d[c]  = 1'b0;
                            cnt_d[c]   = {CNT_W{1'b0}};
                        end else begin
                            cnt_d[c] = cnt_q[c] + CNT_W'(1);
                        end
                    end
                    HALT: begin
                        state_d[c] = IDLE;
                    end
                    default: begin
                        state_d[c] = IDLE;
                        dir_d[c]   = DIR_IDLE;
                        door_d[c]  = 1'b0;
                        cnt_d[c]   = {CNT_W{1'b0}};
                    end
                endcase
            end
            // A car standing with its door open absorbs new calls for its floor.
            if (state_q[c] == DOOR_OPEN) begin
                clear_s = clear_s | (4'b0001 << floor_q[c]);
            end else begin
                clear_s = clear_s;
            end
        end
        pending_d = halt_s ? 4'b0000 : ((pending_q | arbiter_requests) & ~(clear_s | served_d));
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending_q <= 4'b0000;
            served_q  <= 4'b0000;
            floor_q[0] <= 2'd0;
            floor_q[1] <= 2'd3;
            for (int c = 0; c < 2; c++) begin
                state_q[c]  <= IDLE;
                dir_q[c]    <= DIR_IDLE;
                door_q[c]   <= 1'b0;
                target_q[c] <= 2'd0;
                tvalid_q[c] <= 1'b0;
                cnt_q[c]    <= {CNT_W{1'b0}};
            end
        end else begin
            pending_q <= pending_d;
            served_q  <= served_d;
            for (int c = 0; c < 2; c++) begin
                state_q[c]  <= state_d[c];
                floor_q[c]  <= floor_d[c];
                dir_q[c]    <= dir_d[c];
                door_q[c]   <= door_d[c];
                target_q[c] <= target_d[c];
                tvalid_q[c] <= tvalid_d[c];
                cnt_q[c]    <= cnt_d[c];
            end
        end
    end

    assign pending_requests = pending_q;
    assign served_pulse     = served_q;
    assign car_a_floor      = floor_q[0];
    assign car_b_floor      = floor_q[1];
    assign car_a_dir        = dir_q[0];
    assign car_b_dir        = dir_q[1];
    assign car_a_door       = door_q[0];
    assign car_b_door       = door_q[1];

endmodule

// File: tb/tb_dual_car_scheduler.sv
// Directed bench for dual_car_scheduler: expected served pulses are queued by the
// stimulus and checked by an independent monitor; state is spot-checked inline.
module tb_dual_car_scheduler;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] arbiter_requests = 4'b0000;
    logic       emergency_override = 1'b0;
    logic [3:0] pending_requests;
    logic [1:0] car_a_floor, car_b_floor, car_a_dir, car_b_dir;
    logic       car_a_door, car_b_door;
    logic [3:0] served_pulse;

    dual_car_scheduler #(.FLOOR_TRAVEL_CYCLES(4), .DOOR_OPEN_CYCLES(3)) dut (
        .clk(clk), .rst_n(rst_n), .arbiter_requests(arbiter_requests),
        .emergency_override(emergency_override), .pending_requests(pending_requests),
        .car_a_floor(car_a_floor), .car_b_floor(car_b_floor),
        .car_a_dir(car_a_dir), .car_b_dir(car_b_dir),
        .car_a_door(car_a_door), .car_b_door(car_b_door),
        .served_pulse(served_pulse)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [3:0] pulse;
        int         at;
        logic [1:0] af;
        logic [1:0] bf;
    } exp_t;
    exp_t sb_q[$];
    exp_t mon_e;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_exp(input logic [3:0] pulse, input int at, input logic [1:0] af, input logic [1:0] bf);
        exp_t e;
        e.pulse = pulse;
        e.at    = at;
        e.af    = af;
        e.bf    = bf;
        sb_q.push_back(e);
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_pending"}, 32'(pending_requests), 32'd0);
        chk({tag, "_served"},  32'(served_pulse), 32'd0);
        chk({tag, "_a_floor"}, 32'(car_a_floor), 32'd0);
        chk({tag, "_b_floor"}, 32'(car_b_floor), 32'd3);
        chk({tag, "_dirs"},    32'({car_a_dir, car_b_dir}), 32'd0);
        chk({tag, "_doors"},   32'({car_a_door, car_b_door}), 32'd0);
    endtask

    task automatic do_reset();
        rst_n              = 1'b0;
        arbiter_requests   = 4'b0000;
        emergency_override = 1'b0;
        repeat (2) @(negedge clk);
        check_reset("reset");
        rst_n = 1'b1;
    endtask

    // Monitor: every served pulse must match the next queued expectation.
    always @(negedge clk) begin
        if (served_pulse !== 4'b0000) begin
            if (sb_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_pulse: got %b at cycle %0d, expected none", served_pulse, cyc);
            end else begin
                mon_e = sb_q.pop_front();
                chk("pulse_value",   32'(served_pulse), 32'(mon_e.pulse));
                chk("pulse_cycle",   32'(cyc), 32'(mon_e.at));
                chk("pulse_a_floor", 32'(car_a_floor), 32'(mon_e.af));
                chk("pulse_b_floor", 32'(car_b_floor), 32'(mon_e.bf));
            end
        end
    end

    initial begin
        int n, m, a_act, a_up, b_dn, b_dr;

        // Single request for floor 2: B is nearer and serves it.
        do_reset();
        n = cyc;
        arbiter_requests = 4'b0100;
        push_exp(4'b0100, n + 6, 2'd0, 2'd2);
        a_act = 0; b_dn = 0; b_dr = 0;
        for (int i = 1; i <= 14; i++) begin
            @(negedge clk);
            arbiter_requests = 4'b0000;
            if (car_b_dir == 2'b10) b_dn++;
            if (car_b_door) b_dr++;
            if ((car_a_dir != 2'b00) || car_a_door) a_act++;
            if (i == 3) chk("s1_pending_held", 32'(pending_requests), 32'd4);
        end
        chk("s1_b_down_cycles", 32'(b_dn), 32'd4);
        chk("s1_b_door_cycles", 32'(b_dr), 32'd3);
        chk("s1_a_stays_idle",  32'(a_act), 32'd0);
        chk("s1_pending_clear", 32'(pending_requests), 32'd0);
        chk("s1_b_floor",       32'(car_b_floor), 32'd2);
        chk("s1_drained",       32'(sb_q.size()), 32'd0);

        // Floors 1 and 2 together: split between the cars, simultaneous arrival.
        do_reset();
        n = cyc;
        arbiter_requests = 4'b0110;
        push_exp(4'b0110, n + 6, 2'd1, 2'd2);
        a_up = 0; b_dn = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            arbiter_requests = 4'b0000;
            if (car_a_dir == 2'b01) a_up++;
            if (car_b_dir == 2'b10) b_dn++;
        end
        chk("s2_a_up_cycles",   32'(a_up), 32'd4);
        chk("s2_b_down_cycles", 32'(b_dn), 32'd4);
        chk("s2_pending_clear", 32'(pending_requests), 32'd0);
        chk("s2_drained",       32'(sb_q.size()), 32'd0);

        // Request at A's own floor: door opens without motion, repeats are absorbed.
        do_reset();
        n = cyc;
        arbiter_requests = 4'b0001;
        push_exp(4'b0001, n + 2, 2'd0, 2'd3);
        wait_until(n + 1);
        arbiter_requests = 4'b0000;
        chk("s3_pending_latched", 32'(pending_requests), 32'd1);
        chk("s3_door_not_yet",    32'(car_a_door), 32'd0);
        wait_until(n + 2);
        chk("s3_door_open",   32'(car_a_door), 32'd1);
        chk("s3_no_motion",   32'({car_a_dir, car_a_floor}), 32'd0);
        arbiter_requests = 4'b0001;
        wait_until(n + 3);
        chk("s3_absorbed",    32'(pending_requests), 32'd0);
        wait_until(n + 4);
        arbiter_requests = 4'b0000;
        chk("s3_absorbed2",   32'(pending_requests), 32'd0);
        chk("s3_door_last",   32'(car_a_door), 32'd1);
        wait_until(n + 5);
        chk("s3_door_closed", 32'(car_a_door), 32'd0);
        wait_until(n + 8);
        chk("s3_pending_end", 32'(pending_requests), 32'd0);
        chk("s3_drained",     32'(sb_q.size()), 32'd0);

        // B busy, A heads to floor 3, emergency halts it at floor 1.
        do_reset();
        n = cyc;
        arbiter_requests = 4'b0100;
        push_exp(4'b0100, n + 6, 2'd0, 2'd2);
        wait_until(n + 1);
        arbiter_requests = 4'b1000;
        wait_until(n + 2);
        arbiter_requests = 4'b0000;
        chk("s4_b_down", 32'(car_b_dir), 32'd2);
        chk("s4_a_waits", 32'(car_a_dir), 32'd0);
        wait_until(n + 3);
        chk("s4_a_up", 32'(car_a_dir), 32'd1);
        wait_until(n + 7);
        chk("s4_a_floor_step", 32'(car_a_floor), 32'd1);
        emergency_override = 1'b1;
        wait_until(n + 8);
        chk("s4_halt_a_floor", 32'(car_a_floor), 32'd1);
        chk("s4_halt_dirs",    32'({car_a_dir, car_b_dir}), 32'd0);
        chk("s4_halt_doors",   32'({car_a_door, car_b_door}), 32'd0);
        chk("s4_halt_pending", 32'(pending_requests), 32'd0);
        arbiter_requests = 4'b0010;
        wait_until(n + 10);
        chk("s4_req_ignored", 32'(pending_requests), 32'd0);
        chk("s4_b_floor_held", 32'(car_b_floor), 32'd2);
        arbiter_requests   = 4'b0000;
        emergency_override = 1'b0;
        m = n + 11;
        wait_until(m);
        chk("s4_release_idle",    32'({car_a_dir, car_a_door}), 32'd0);
        chk("s4_release_floor",   32'(car_a_floor), 32'd1);
        chk("s4_release_pending", 32'(pending_requests), 32'd0);
        arbiter_requests = 4'b0001;
        wait_until(m + 1);
        arbiter_requests = 4'b0000;
        chk("s4_no_early_move", 32'(car_a_dir), 32'd0);
        chk("s4_new_pending",   32'(pending_requests), 32'd1);
        wait_until(m + 2);
        chk("s4_move_after_m2", 32'(car_a_dir), 32'd2);
        push_exp(4'b0001, m + 6, 2'd0, 2'd2);
        wait_until(m + 12);
        chk("s4_a_at_ground", 32'(car_a_floor), 32'd0);
        chk("s4_drained",     32'(sb_q.size()), 32'd0);

        // Both cars busy: floor 1 waits for the first idle car; then reset mid-move.
        do_reset();
        n = cyc;
        arbiter_requests = 4'b0101;
        push_exp(4'b0001, n + 2, 2'd0, 2'd3);
        push_exp(4'b0100, n + 6, 2'd0, 2'd2);
        wait_until(n + 1);
        arbiter_requests = 4'b0010;
        wait_until(n + 2);
        arbiter_requests = 4'b0000;
        chk("s5_pending_busy", 32'(pending_requests), 32'd6);
        wait_until(n + 5);
        chk("s5_still_pending", 32'(pending_requests), 32'd6);
        chk("s5_a_idle",        32'({car_a_dir, car_a_door}), 32'd0);
        wait_until(n + 6);
        chk("s5_a_assigned",    32'(car_a_dir), 32'd1);
        chk("s5_pending_after", 32'(pending_requests), 32'd2);
        wait_until(n + 8);
        rst_n = 1'b0;
        wait_until(n + 9);
        check_reset("s5_midmove");
        rst_n = 1'b1;
        wait_until(n + 16);
        chk("s5_no_resume", 32'({car_a_dir, car_b_dir, pending_requests}), 32'd0);
        chk("s5_drained",   32'(sb_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
